led_sync_fifo: RTL and testbench

- Parametrised single-clock FIFO for the LED backlight path. Buffers per-zone dimming values between the zone statistics engine and the LED driver serialiser.
- Generalises the 8-bit/1024-deep LED FIFO with:
  - configurable width and depth;
  - programmable almost-full and almost-empty thresholds;
  - standard or first-word-fall-through (FWFT) read mode;
  - live fill level output;
  - synchronous flush;
  - sticky overflow and underflow error flags.
- Storage is an inferred simple-dual-port RAM with a 1-cycle read.

---
 rtl/led_sync_fifo.sv | 188 ++++++++++++++++++
 tb/tb_led_sync_fifo.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sync_fifo.sv
// ---------------------------------------------------------------------------
// led_sync_fifo
//   Single-clock FIFO that buffers per-zone dimming values between the zone
//   statistics engine and the LED driver serialiser. Storage is an inferred
//   simple-dual-port RAM with a registered 1-cycle read. The FIFO supports
//   standard or first-word-fall-through read mode, programmable almost-full
//   and almost-empty thresholds, a live fill level, a synchronous flush, and
//   sticky overflow/underflow flags.
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   flush         synchronous clear of contents and flags (rd_data holds)
//   wr_en/wr_data write request and data
//   wr_full       level == capacity
//   almost_full   level >= ALMOST_FULL_NUM
//   rd_en         read request (FWFT: pop the head word)
//   rd_data       read data
//   rd_valid      rd_data holds a valid word this cycle
//   rd_empty      no readable word
//   almost_empty  level <= ALMOST_EMPTY_NUM
//   water_level   words held, 0..capacity
//   overflow      sticky: wr_en seen while wr_full
//   underflow     sticky: rd_en seen while rd_empty
// ---------------------------------------------------------------------------
module led_sync_fifo #(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned DEPTH_WIDTH      = 10,
    parameter int unsigned FWFT             = 0,
    parameter int unsigned ALMOST_FULL_NUM  = 1020,
    parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_full,
    output logic                   almost_full,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic                   rd_empty,
    output logic                   almost_empty,
    output logic [DEPTH_WIDTH:0]   water_level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned          CAP      = 1 << DEPTH_WIDTH;
    localparam bit                   FWFT_MODE = (FWFT != 0);
    localparam logic [DEPTH_WIDTH:0] CAP_LVL  = (DEPTH_WIDTH+1)'(CAP);
    localparam logic [DEPTH_WIDTH:0] AF_LVL   = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [DEPTH_WIDTH:0] AE_LVL   = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

    logic [DATA_WIDTH-1:0]  mem [CAP];

    logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_WIDTH:0]   level_q, level_d;
    logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic                   head_q, head_d;      // FWFT output register occupied
    logic                   full_q, full_d;
    logic                   afull_q, afull_d;
    logic                   empty_q, empty_d;
    logic                   aempty_q, aempty_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;
    logic                   udf_q, udf_d;

    logic                   wr_acc;
    logic                   rd_acc;
    logic                   ram_rd;              // RAM read issued this edge
    logic                   ram_has_word;

    always_comb begin
        wr_acc       = wr_en & ~full_q;
        rd_acc       = rd_en & ~empty_q;

        // In FWFT mode the level includes the output register, so the RAM
        // holds words exactly when the level exceeds the head occupancy.
        ram_has_word = (level_q > {{DEPTH_WIDTH{1'b0}}, head_q});

        // FWFT prefetches whenever the output register is free or being
        // popped; a word written on this same edge is not yet in the RAM,
        // which is why write-and-pop of the last word costs one bubble.
        if (FWFT_MODE) begin
            ram_rd = ram_has_word & (~head_q | rd_acc);
        end else begin
            ram_rd = rd_acc;
        end

        head_d = head_q;
        if (FWFT_MODE) begin
            if (ram_rd) begin
                head_d = 1'b1;
            end else if (rd_acc) begin
                head_d = 1'b0;
            end
        end

        level_d = level_q;
        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + (DEPTH_WIDTH+1)'(1);
            2'b01:   level_d = level_q - (DEPTH_WIDTH+1)'(1);
            default: level_d = level_q;
        endcase

        wr_ptr_d  = wr_acc ? wr_ptr_q + DEPTH_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d  = ram_rd ? rd_ptr_q + DEPTH_WIDTH'(1) : rd_ptr_q;
        rd_data_d = ram_rd ? mem[rd_ptr_q] : rd_data_q;

        full_d   = (level_d == CAP_LVL);
        afull_d  = (level_d >= AF_LVL);
        aempty_d = (level_d <= AE_LVL);

        if (FWFT_MODE) begin
            empty_d = ~head_d;
            valid_d = head_d;
        end else begin
            empty_d = (level_d == '0);
            valid_d = rd_acc;
        end

        ovf_d = ovf_q | (wr_en & full_q);
        udf_d = udf_q | (rd_en & empty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
            head_q    <= 1'b0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            empty_q   <= 1'b1;
            aempty_q  <= 1'b1;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else if (flush) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            head_q    <= 1'b0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            empty_q   <= 1'b1;
            aempty_q  <= 1'b1;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
            head_q    <= head_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            empty_q   <= empty_d;
            aempty_q  <= aempty_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    // RAM write port kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst && !flush) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign wr_full      = full_q;
    assign almost_full  = afull_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = valid_q;
    assign rd_empty     = empty_q;
    assign almost_empty = aempty_q;
    assign water_level  = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_led_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_led_sync_fifo
//   Directed bench for led_sync_fifo. Two instances share the clock: u_std
//   (standard read mode) and u_fwft (first-word-fall-through), both with a
//   16-deep, 8-bit configuration, almost_full at 14 and almost_empty at 2.
// ---------------------------------------------------------------------------
module tb_led_sync_fifo;

    logic       clk;
    logic       rst;

    logic       a_flush, a_wr_en, a_rd_en;
    logic [7:0] a_wr_data, a_rd_data;
    logic       a_wr_full, a_afull, a_rd_valid, a_rd_empty, a_aempty, a_ovf, a_udf;
    logic [4:0] a_level;

    logic       b_flush, b_wr_en, b_rd_en;
    logic [7:0] b_wr_data, b_rd_data;
    logic       b_wr_full, b_afull, b_rd_valid, b_rd_empty, b_aempty, b_ovf, b_udf;
    logic [4:0] b_level;

    int checks = 0;
    int errors = 0;

    led_sync_fifo #(
        .DATA_WIDTH(8), .DEPTH_WIDTH(4), .FWFT(0),
        .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)
    ) u_std (
        .clk(clk), .rst(rst), .flush(a_flush),
        .wr_en(a_wr_en), .wr_data(a_wr_data), .wr_full(a_wr_full),
        .almost_full(a_afull), .rd_en(a_rd_en), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .rd_empty(a_rd_empty), .almost_empty(a_aempty),
        .water_level(a_level), .overflow(a_ovf), .underflow(a_udf)
    );

    led_sync_fifo #(
        .DATA_WIDTH(8), .DEPTH_WIDTH(4), .FWFT(1),
        .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)
    ) u_fwft (
        .clk(clk), .rst(rst), .flush(b_flush),
        .wr_en(b_wr_en), .wr_data(b_wr_data), .wr_full(b_wr_full),
        .almost_full(b_afull), .rd_en(b_rd_en), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .rd_empty(b_rd_empty), .almost_empty(b_aempty),
        .water_level(b_level), .overflow(b_ovf), .underflow(b_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({a_wr_full, a_afull, a_rd_empty, a_aempty, a_rd_valid, a_ovf, a_udf} !== 7'b0011000) begin
            errors++;
            $display("FAIL reset_std_flags got %b want 0011000",
                     {a_wr_full, a_afull, a_rd_empty, a_aempty, a_rd_valid, a_ovf, a_udf});
        end
        checks++;
        if (a_level !== 5'd0 || a_rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_std_level_data got level=%0d data=%h want 0/00", a_level, a_rd_data);
        end
        checks++;
        if ({b_wr_full, b_afull, b_rd_empty, b_aempty, b_rd_valid, b_ovf, b_udf} !== 7'b0011000) begin
            errors++;
            $display("FAIL reset_fwft_flags got %b want 0011000",
                     {b_wr_full, b_afull, b_rd_empty, b_aempty, b_rd_valid, b_ovf, b_udf});
        end
        checks++;
        if (b_level !== 5'd0 || b_rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_fwft_level_data got level=%0d data=%h want 0/00", b_level, b_rd_data);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            a_wr_en   = 1'b1;
            a_wr_data = 8'(i);
            tick();
            checks++;
            if (a_level !== 5'(i + 1)) begin
                errors++;
                $display("FAIL fill_level[%0d] got %0d want %0d", i, a_level, i + 1);
            end
            checks++;
            if (a_aempty !== ((i + 1) <= 2) || a_afull !== ((i + 1) >= 14) ||
                a_wr_full !== (i == 15) || a_rd_empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_flags[%0d] got ae=%b af=%b full=%b empty=%b want %b %b %b 0",
                         i, a_aempty, a_afull, a_wr_full, a_rd_empty,
                         ((i + 1) <= 2), ((i + 1) >= 14), (i == 15));
            end
        end
        a_wr_data = 8'hFF;
        tick();
        a_wr_en = 1'b0;
        checks++;
        if (a_ovf !== 1'b1 || a_level !== 5'd16 || a_wr_full !== 1'b1) begin
            errors++;
            $display("FAIL fill_overflow got ovf=%b level=%0d full=%b want 1/16/1", a_ovf, a_level, a_wr_full);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            a_rd_en = 1'b1;
            tick();
            checks++;
            if (a_rd_valid !== 1'b1 || a_rd_data !== 8'(i) || a_level !== 5'(15 - i)) begin
                errors++;
                $display("FAIL drain[%0d] got valid=%b data=%h level=%0d want 1/%h/%0d",
                         i, a_rd_valid, a_rd_data, a_level, 8'(i), 15 - i);
            end
        end
        a_rd_en = 1'b0;
        tick();
        checks++;
        if (a_rd_valid !== 1'b0 || a_rd_empty !== 1'b1 || a_level !== 5'd0 || a_rd_data !== 8'h0F) begin
            errors++;
            $display("FAIL drain_idle got valid=%b empty=%b level=%0d data=%h want 0/1/0/0f",
                     a_rd_valid, a_rd_empty, a_level, a_rd_data);
        end
        a_rd_en = 1'b1;
        tick();
        a_rd_en = 1'b0;
        checks++;
        if (a_udf !== 1'b1 || a_rd_valid !== 1'b0 || a_rd_data !== 8'h0F) begin
            errors++;
            $display("FAIL drain_underflow got udf=%b valid=%b data=%h want 1/0/0f", a_udf, a_rd_valid, a_rd_data);
        end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_wr_en   = 1'b1;
            a_wr_data = 8'(i);
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            a_wr_en   = 1'b1;
            a_rd_en   = 1'b1;
            a_wr_data = 8'(8 + i);
            tick();
            checks++;
            if (a_rd_data !== 8'(i) || a_rd_valid !== 1'b1 || a_level !== 5'd8) begin
                errors++;
                $display("FAIL b2b[%0d] got data=%h valid=%b level=%0d want %h/1/8",
                         i, a_rd_data, a_rd_valid, a_level, 8'(i));
            end
        end
        a_wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (a_rd_data !== 8'(40 + i) || a_level !== 5'(7 - i)) begin
                errors++;
                $display("FAIL b2b_drain[%0d] got data=%h level=%0d want %h/%0d",
                         i, a_rd_data, a_level, 8'(40 + i), 7 - i);
            end
        end
        a_rd_en = 1'b0;
        checks++;
        if (a_ovf !== 1'b0 || a_udf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_errflags got ovf=%b udf=%b want 0/0", a_ovf, a_udf);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 17; i++) begin
            a_wr_en   = 1'b1;
            a_wr_data = 8'(8'h50 + i);
            tick();
        end
        checks++;
        if (a_level !== 5'd16 || a_ovf !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup got level=%0d ovf=%b want 16/1", a_level, a_ovf);
        end
        a_flush = 1'b1;
        a_rd_en = 1'b1;
        tick();
        a_flush = 1'b0;
        a_wr_en = 1'b0;
        a_rd_en = 1'b0;
        checks++;
        if (a_level !== 5'd0 || a_rd_empty !== 1'b1 || a_wr_full !== 1'b0 ||
            a_ovf !== 1'b0 || a_udf !== 1'b0 || a_rd_valid !== 1'b0 || a_aempty !== 1'b1) begin
            errors++;
            $display("FAIL flush_state got level=%0d empty=%b full=%b ovf=%b udf=%b valid=%b ae=%b want 0/1/0/0/0/0/1",
                     a_level, a_rd_empty, a_wr_full, a_ovf, a_udf, a_rd_valid, a_aempty);
        end
        checks++;
        if (a_rd_data !== 8'h2F) begin
            errors++;
            $display("FAIL flush_rd_data_hold got %h want 2f", a_rd_data);
        end
        a_wr_en   = 1'b1;
        a_wr_data = 8'h3C;
        tick();
        a_wr_en = 1'b0;
        a_rd_en = 1'b1;
        tick();
        a_rd_en = 1'b0;
        checks++;
        if (a_rd_data !== 8'h3C || a_rd_valid !== 1'b1 || a_level !== 5'd0) begin
            errors++;
            $display("FAIL flush_reuse got data=%h valid=%b level=%0d want 3c/1/0", a_rd_data, a_rd_valid, a_level);
        end
    endtask

    task automatic test_fwft_basic();
        b_wr_en   = 1'b1;
        b_wr_data = 8'hA5;
        tick();
        b_wr_en = 1'b0;
        checks++;
        if (b_rd_empty !== 1'b1 || b_level !== 5'd1) begin
            errors++;
            $display("FAIL fwft_first_edge got empty=%b level=%0d want 1/1", b_rd_empty, b_level);
        end
        tick();
        checks++;
        if (b_rd_empty !== 1'b0 || b_rd_valid !== 1'b1 || b_rd_data !== 8'hA5 || b_level !== 5'd1) begin
            errors++;
            $display("FAIL fwft_head got empty=%b valid=%b data=%h level=%0d want 0/1/a5/1",
                     b_rd_empty, b_rd_valid, b_rd_data, b_level);
        end
        b_rd_en = 1'b1;
        tick();
        b_rd_en = 1'b0;
        checks++;
        if (b_rd_empty !== 1'b1 || b_rd_valid !== 1'b0 || b_level !== 5'd0 || b_udf !== 1'b0) begin
            errors++;
            $display("FAIL fwft_pop got empty=%b valid=%b level=%0d udf=%b want 1/0/0/0",
                     b_rd_empty, b_rd_valid, b_level, b_udf);
        end
    endtask

    task automatic test_fwft_write_pop();
        b_wr_en   = 1'b1;
        b_wr_data = 8'h77;
        tick();
        b_wr_en = 1'b0;
        tick();
        b_wr_en   = 1'b1;
        b_wr_data = 8'h11;
        b_rd_en   = 1'b1;
        tick();
        b_wr_en = 1'b0;
        b_rd_en = 1'b0;
        checks++;
        if (b_rd_empty !== 1'b1 || b_level !== 5'd1) begin
            errors++;
            $display("FAIL fwft_wp_bubble got empty=%b level=%0d want 1/1", b_rd_empty, b_level);
        end
        tick();
        checks++;
        if (b_rd_empty !== 1'b0 || b_rd_data !== 8'h11 || b_level !== 5'd1) begin
            errors++;
            $display("FAIL fwft_wp_after got empty=%b data=%h level=%0d want 0/11/1", b_rd_empty, b_rd_data, b_level);
        end
        // Stream: pop with more words queued must not bubble.
        b_wr_en   = 1'b1;
        b_wr_data = 8'h22;
        tick();
        b_wr_data = 8'h33;
        tick();
        b_wr_en = 1'b0;
        b_rd_en = 1'b1;
        tick();
        checks++;
        if (b_rd_empty !== 1'b0 || b_rd_data !== 8'h22 || b_level !== 5'd2) begin
            errors++;
            $display("FAIL fwft_stream1 got empty=%b data=%h level=%0d want 0/22/2", b_rd_empty, b_rd_data, b_level);
        end
        tick();
        checks++;
        if (b_rd_empty !== 1'b0 || b_rd_data !== 8'h33 || b_level !== 5'd1) begin
            errors++;
            $display("FAIL fwft_stream2 got empty=%b data=%h level=%0d want 0/33/1", b_rd_empty, b_rd_data, b_level);
        end
        tick();
        checks++;
        if (b_rd_empty !== 1'b1 || b_level !== 5'd0 || b_udf !== 1'b0) begin
            errors++;
            $display("FAIL fwft_stream_end got empty=%b level=%0d udf=%b want 1/0/0", b_rd_empty, b_level, b_udf);
        end
        tick();
        b_rd_en = 1'b0;
        checks++;
        if (b_udf !== 1'b1) begin
            errors++;
            $display("FAIL fwft_underflow got %b want 1", b_udf);
        end
    endtask

    task automatic test_fwft_capacity();
        b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b_wr_en   = 1'b1;
            b_wr_data = 8'(8'hC0 + i);
            tick();
        end
        b_wr_en = 1'b0;
        checks++;
        if (b_wr_full !== 1'b1 || b_level !== 5'd16 || b_afull !== 1'b1 || b_ovf !== 1'b0 || b_rd_data !== 8'hC0) begin
            errors++;
            $display("FAIL fwft_full got full=%b level=%0d af=%b ovf=%b head=%h want 1/16/1/0/c0",
                     b_wr_full, b_level, b_afull, b_ovf, b_rd_data);
        end
        for (int i = 0; i < 15; i++) begin
            b_rd_en = 1'b1;
            tick();
            checks++;
            if (b_rd_data !== 8'(8'hC1 + i) || b_rd_empty !== 1'b0 || b_level !== 5'(15 - i)) begin
                errors++;
                $display("FAIL fwft_drain[%0d] got data=%h empty=%b level=%0d want %h/0/%0d",
                         i, b_rd_data, b_rd_empty, b_level, 8'(8'hC1 + i), 15 - i);
            end
        end
        tick();
        b_rd_en = 1'b0;
        checks++;
        if (b_rd_empty !== 1'b1 || b_level !== 5'd0 || b_aempty !== 1'b1) begin
            errors++;
            $display("FAIL fwft_drain_end got empty=%b level=%0d ae=%b want 1/0/1", b_rd_empty, b_level, b_aempty);
        end
    endtask

    initial begin
        rst = 1'b0;
        a_flush = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0; a_wr_data = '0;
        b_flush = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_data = '0;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_fwft_basic();
        test_fwft_write_pop();
        test_fwft_capacity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
